// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//   Iterative multiply/divide unit holding the architectural HI/LO registers.
//   Accepts MULT/MULTU/DIV/DIVU from the ALU control decoder. Each operation
//   runs for 32 iterations and then writes HI/LO. It also services MTHI/MTLO
//   writes while idle.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-high reset, clears all state
//   start    in   request qualifier for alu_ctl/op_a/op_b
//   alu_ctl  in   4-bit ALU control: 3 DIV, 4 DIVU, 11 MULT, 12 MULTU
//   op_a     in   rs value (multiplicand / dividend)
//   op_b     in   rt value (multiplier / divisor)
//   hi_we    in   MTHI write enable (honoured only when idle)
//   lo_we    in   MTLO write enable (honoured only when idle)
//   wdata    in   MTHI/MTLO data
//   hi, lo   out  HI/LO registers
//   busy     out  operation in progress (registered)
//   done     out  one-cycle pulse in the first cycle HI/LO show a result
//
// State   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for a request; MTHI/MTLO writes accepted
// RUN     | one multiply or divide iteration per clock, 32 in total
// FINISH  | sign fix-up, HI/LO write, done pulse, return to IDLE
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam logic [3:0] CTL_DIV   = 4'd3;
  localparam logic [3:0] CTL_DIVU  = 4'd4;
  localparam logic [3:0] CTL_MULT  = 4'd11;
  localparam logic [3:0] CTL_MULTU = 4'd12;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic             is_div;
  logic             neg_main;   // product or quotient must be negated
  logic             neg_rem;    // remainder must be negated (dividend negative)
  logic             div_zero;
  logic [WIDTH-1:0] raw_a;      // unmodified dividend for the divide-by-zero result
  logic [WIDTH-1:0] operand;    // multiplicand or divisor magnitude
  // Multiply: {acc_hi[W-1:0], acc_lo} is the shifting product/multiplier.
  // Divide:   acc_hi is the W+1-bit partial remainder, acc_lo shifts the
  //           dividend out at the top and the quotient in at the bottom.
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;

  // ---------------------------------------------------------------------------
  // Request decode and operand magnitudes
  // ---------------------------------------------------------------------------
  logic             req_valid;
  logic             req_div;
  logic             req_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  always_comb begin
    req_div    = (alu_ctl == CTL_DIV) || (alu_ctl == CTL_DIVU);
    req_signed = (alu_ctl == CTL_DIV) || (alu_ctl == CTL_MULT);
    req_valid  = start && (req_div || (alu_ctl == CTL_MULT) || (alu_ctl == CTL_MULTU));
    a_neg      = req_signed && op_a[WIDTH-1];
    b_neg      = req_signed && op_b[WIDTH-1];
    // Negating the most negative value yields itself, which is the correct
    // unsigned magnitude.
    a_mag      = a_neg ? (~op_a + 1'b1) : op_a;
    b_mag      = b_neg ? (~op_b + 1'b1) : op_b;
  end

  // ---------------------------------------------------------------------------
  // One iteration
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH:0]   iter_hi;
  logic [WIDTH-1:0] iter_lo;

  always_comb begin
    mul_sum   = {1'b0, acc_hi[WIDTH-1:0]} + (acc_lo[0] ? {1'b0, operand} : '0);
    div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    div_trial = div_shift - {1'b0, operand};
    iter_hi   = '0;
    iter_lo   = '0;
    if (is_div) begin
      // Restore when the trial subtraction goes negative.
      iter_hi = div_trial[WIDTH] ? div_shift : div_trial;
      iter_lo = {acc_lo[WIDTH-2:0], ~div_trial[WIDTH]};
    end else begin
      // Shift the carry-extended sum right by one together with the multiplier.
      iter_hi = {1'b0, mul_sum[WIDTH:1]};
      iter_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Final result with sign fix-up
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] product_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  always_comb begin
    product     = {acc_hi[WIDTH-1:0], acc_lo};
    product_fix = neg_main ? (~product + 1'b1) : product;
    quot_fix    = neg_main ? (~acc_lo + 1'b1) : acc_lo;
    rem_fix     = neg_rem  ? (~acc_hi[WIDTH-1:0] + 1'b1) : acc_hi[WIDTH-1:0];
    res_hi      = product_fix[2*WIDTH-1:WIDTH];
    res_lo      = product_fix[WIDTH-1:0];
    if (is_div) begin
      if (div_zero) begin
        res_hi = raw_a;
        res_lo = '1;
      end else begin
        res_hi = rem_fix;
        res_lo = quot_fix;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      is_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      raw_a    <= '0;
      operand  <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A same-cycle MTHI/MTLO still lands; the result overwrites it later.
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (req_valid) begin
            state    <= RUN;
            busy     <= 1'b1;
            count    <= '0;
            is_div   <= req_div;
            neg_main <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= req_div && (op_b == '0);
            raw_a    <= op_a;
            operand  <= req_div ? b_mag : a_mag;
            acc_hi   <= '0;
            acc_lo   <= req_div ? a_mag : b_mag;
          end
        end
        RUN: begin
          acc_hi <= iter_hi;
          acc_lo <= iter_lo;
          count  <= count + 1'b1;
          if (count == LAST_ITER) state <= FINISH;
        end
        FINISH: begin
          hi    <= res_hi;
          lo    <= res_lo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit with architectural HI/LO registers, sitting directly downstream of the ALU control decoder in the MIPS datapath. It consumes the 4-bit ALU control code for MULT (11), MULTU (12), DIV (3) and DIVU (4), and computes over 32 iterations. While it runs, it holds `busy` so the control path stalls MFHI/MFLO. It also services MTHI/MTLO writes and drives HI/LO to the writeback mux.

## Interface
- `WIDTH`, 32, operand width; HI and LO are each WIDTH bits.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  request qualifier; sampled with `alu_ctl`, `op_a`, `op_b`.
- `alu_ctl`  in  4  ALU control code; only 3, 4, 11, 12 act.
- `op_a`  in  WIDTH  rs value: multiplicand or dividend.
- `op_b`  in  WIDTH  rt value: multiplier or divisor.
- `hi_we`  in  1  MTHI write enable.
- `lo_we`  in  1  MTLO write enable.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse when HI/LO take a result.

## Operation
- State machine: IDLE, RUN, FINISH.
- **IDLE**
  - `start`=1 with `alu_ctl` in {3,4,11,12} latches the operands, records the op and signedness, and goes to RUN with counter=0.
  - Any other `alu_ctl` with `start`=1 is ignored.
- **Signed ops**
  - Operands are converted to magnitudes on capture.
  - Sign flags are stored for fix-up in FINISH.
- **RUN, multiply**
  - Shift-add on a 2*WIDTH accumulator, one multiplier bit per cycle.
  - Exact 64-bit product, no truncation.
- **RUN, divide**
  - Restoring division with a WIDTH+1-bit partial remainder, one quotient bit per cycle.
- **RUN, exit**
  - After the 32nd iteration the unit goes to FINISH.
- **FINISH, result write**
  - Multiply: HI = product[63:32], LO = product[31:0]; negate the full 64 bits if the signs differ.
  - Divide: LO = quotient, HI = remainder.
  - Quotient truncates toward zero and is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
- **FINISH, exit**
  - Pulse `done` and return to IDLE.
- **Divide by zero** (DIV or DIVU, `op_b`=0)
  - Normal latency.
  - LO = 0xFFFFFFFF, HI = `op_a` (raw input value); signed fix-up is bypassed.
- **DIV 0x80000000 / 0xFFFFFFFF**: LO = 0x80000000, HI = 0. This is the natural magnitude result; there is no trap.
- **MTHI/MTLO**
  - In IDLE, `hi_we`/`lo_we` write `wdata` to HI/LO at the clock edge.
  - While `busy`=1 they are ignored.
  - When `start` (valid) and a write occur in the same IDLE cycle, the write takes effect; the operation result later overwrites both registers.
- **`start` while busy**: ignored, and is not queued.

## Timing
- **Reset values**: `hi`=0, `lo`=0, `busy`=0, `done`=0, state=IDLE.
- **Reset is asynchronous**
  - An assertion mid-operation aborts immediately.
  - No `done` is produced and HI/LO clear to 0.
- **Latency, counting from edge E0 at which a valid `start` is sampled**
  - E1..E32: the 32 iterations.
  - E33: the FINISH edge, at which HI/LO update.
- **`busy`**
  - Registered output, 1 in the cycles between E0 and E33 (33 cycles).
  - 0 from E33 onward.
- **`done`**
  - Registered output, 1 exactly in the cycle following E33.
  - That is the first cycle in which `hi`/`lo` show the new result.
- **Back-to-back operation**
  - A new `start` is accepted at E34 at the earliest (the unit is IDLE with `busy`=0 during the cycle between E33 and E34).
  - Throughput is one operation per 34 cycles.
- **Stable outputs**: `hi`/`lo` change only at E33 of an operation, on an IDLE MTHI/MTLO write, or on reset.

## Test plan
- **MULTU**: `op_a`=0xFFFFFFFF, `op_b`=0xFFFFFFFF
  - `busy` high for 33 cycles.
  - `done` in the cycle after E33.
  - HI=0xFFFFFFFE, LO=0x00000001.
- **MULT**: -3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- **DIV**
  - -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - 7 / -2 → LO=0xFFFFFFFD, HI=1.
  - 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- **DIVU**: 7 / 0 → LO=0xFFFFFFFF, HI=7, with normal latency.
- **Ignored requests**
  - Setup: start MULTU 2×3.
  - Stimulus: at cycle 5 assert `start` with DIVU 100/10, and also `hi_we`=1 with `wdata`=0x1234.
  - Required: result HI=0, LO=6; the second op and the write are both ignored.
  - Afterwards: MTLO 0xABCD in IDLE gives LO=0xABCD on the next cycle.
- **Reset mid-operation**
  - Stimulus: start DIV, then assert `reset` asynchronously 10 cycles later.
  - Required: `busy`=0 and HI=LO=0 immediately; no `done` pulse.
  - After release, a fresh MULTU 4×4 gives LO=16 at the normal latency.
